// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//                Defines the fetch FSM state encoding, the prefetch FIFO entry
//                layout {pc, instr}, and the instruction width / PC increment.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous prefetch FIFO of fetch_entry_t. Flush has
//                priority over push and pop. The head entry is read straight
//                from storage, so it stays stable while the FIFO is not popped.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          in   clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    push_i       in   write push_data_i at the tail
//    push_data_i  in   entry to write
//    pop_i        in   remove the head entry
//    flush_i      in   discard all entries (push/pop ignored)
//    count_o      out  number of stored entries
//    valid_o      out  FIFO not empty
//    head_o       out  head entry
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push_i,
    input  fetch_entry_t                      push_data_i,
    input  logic                              pop_i,
    input  logic                              flush_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              valid_o,
    output fetch_entry_t                      head_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    fetch_entry_t     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Pop is only honoured when something is stored; push is accepted on a
    // full FIFO only if the head leaves in the same cycle.
    always_comb begin
        w_do_pop  = pop_i  && !flush_i && (count_q != '0);
        w_do_push = push_i && !flush_i && ((count_q != c_DEPTH) || w_do_pop);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap by natural overflow.
            if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives the word address
//                of a synchronous instruction memory, captures the returned
//                word one cycle later into a prefetch FIFO and hands
//                {pc, instr} to decode with a valid/ready handshake.
//                Supports branch redirect (with flush) and fetch enable/halt.
//                Optional macro FETCH_PERF_EN adds saturating perf counters.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk               in   clock, rising edge
//    rst_n             in   asynchronous active-low reset
//    fetch_en          in   allow new fetch issue
//    br_valid          in   redirect request (single-cycle pulse)
//    br_target         in   redirect byte address, bits [1:0] ignored
//    imem_addr         out  memory word address = {2'b00, pc[31:2]}
//    imem_instruction  in   memory data, valid the cycle after the address
//    out_valid         out  FIFO head valid
//    out_ready         in   decode accepts the head
//    out_pc            out  byte PC of the head
//    out_instr         out  instruction of the head
//    perf_fetched      out  (FETCH_PERF_EN) accepted instructions
//    perf_bubble       out  (FETCH_PERF_EN) ready-but-empty cycles while active
//    perf_redirect     out  (FETCH_PERF_EN) redirect requests
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubble,
    output logic [31:0]        perf_redirect
`endif
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   c_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              w_issue;
    logic              w_flush;
    logic              w_pop_req;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occupancy;
    logic              w_fifo_valid;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (redirect outranks fetch_en)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (br_valid) begin
            state_d = S_REDIR;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = fetch_en ? S_RUN  : S_IDLE;
                S_RUN:   state_d = fetch_en ? S_RUN  : S_IDLE;
                S_REDIR: state_d = fetch_en ? S_RUN  : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (issue / flush)
    // Occupancy counts the stored entries plus the word already in flight,
    // minus the head leaving this cycle, so a full FIFO cannot overflow.
    // The cycle after a redirect also issues (when enabled) so the target
    // word reaches decode three cycles after br_valid.
    // ------------------------------------------------------------------
    always_comb begin
        w_flush     = br_valid;
        w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(inflight_q)
                    - (CNT_W + 1)'(w_pop_req);
        w_issue     = 1'b0;
        if (!br_valid && (w_occupancy < c_DEPTH)) begin
            unique case (state_q)
                S_RUN:   w_issue = 1'b1;
                S_REDIR: w_issue = fetch_en;
                default: w_issue = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC and in-flight tag
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = w_issue;
        inflight_pc_d = inflight_pc_q;
        if (br_valid) begin
            pc_d = {br_target[ADDR_W-1:2], 2'b00};
        end else if (w_issue) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
        if (w_issue) begin
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_addr = {2'b00, pc_q[ADDR_W-1:2]};

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // A response arriving in a redirect cycle belongs to the old stream and
    // is dropped; a pop in that cycle is ignored because everything flushes.
    // ------------------------------------------------------------------
    assign w_pop_req    = w_fifo_valid && out_ready;
    assign w_pop        = w_pop_req && !br_valid;
    assign w_push       = inflight_q && !br_valid;
    assign w_push_entry = '{pc: 32'(inflight_pc_q), instr: imem_instruction};

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .count_o     (w_count),
        .valid_o     (w_fifo_valid),
        .head_o      (w_head)
    );

    assign out_valid = w_fifo_valid;
    assign out_pc    = ADDR_W'(w_head.pc);
    assign out_instr = w_head.instr;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_redirect_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q  <= '0;
            perf_bubble_q   <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (w_pop && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (out_ready && !w_fifo_valid && (state_q != S_IDLE)
                && (perf_bubble_q != '1)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
            if (br_valid && (perf_redirect_q != '1)) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_bubble   = perf_bubble_q;
    assign perf_redirect = perf_redirect_q;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A registered
//                memory model returns word k = 32'hE000_0000 + k one cycle
//                after the address. Inputs change and outputs are sampled on
//                the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
    logic [31:0] perf_redirect;
`endif

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_pc;

    fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en         (fetch_en),
        .br_valid         (br_valid),
        .br_target        (br_target),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_bubble      (perf_bubble),
        .perf_redirect    (perf_redirect)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: word k holds E000_0000 + k.
    always @(posedge clk) begin
        imem_instruction <= 32'hE000_0000 + imem_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    // Check the head equals the next expected sequential entry, accept it.
    task automatic step_pop(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_pc"},    out_pc,    exp_pc);
        check_eq({tag, "_instr"}, out_instr, 32'hE000_0000 + (exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
        next_cyc();
    endtask

    // Called on the edge where the FSM is about to leave S_IDLE/S_REDIR:
    // output stays invalid for two cycles, then the first word appears.
    task automatic expect_start(input string tag);
        next_cyc();
        check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
        next_cyc();
        check_eq({tag, "_lat2"}, 32'(out_valid), 32'd0);
        next_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_pc    = RESET_PC;
        rst_n     = 1'b0;
        fetch_en  = 1'b0;
        br_valid  = 1'b0;
        br_target = 32'h0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) next_cyc();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pc",    out_pc,    32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_addr",  imem_addr, RESET_PC >> 2);
`ifdef FETCH_PERF_EN
        check_eq("rst_perf_f", perf_fetched,  32'd0);
        check_eq("rst_perf_b", perf_bubble,   32'd0);
        check_eq("rst_perf_r", perf_redirect, 32'd0);
`endif
        rst_n = 1'b1;
        next_cyc();
        check_eq("idle_valid", 32'(out_valid), 32'd0);

        // ---------------- streaming ----------------
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        exp_pc    = RESET_PC;
        expect_start("stream");
        for (int i = 0; i < 8; i++) step_pop("stream");

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_pc",    out_pc,    exp_pc);
            check_eq("bp_instr", out_instr, 32'hE000_0000 + (exp_pc >> 2));
        end
        // Head + one more are held; pc parked two words past the head.
        check_eq("bp_addr", imem_addr, (exp_pc + 32'd8) >> 2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step_pop("bp_rel");

        // ---------------- redirect ----------------
        br_valid  = 1'b1;
        br_target = 32'h0000_0040;
        next_cyc();
        br_valid = 1'b0;
        check_eq("redir_valid1", 32'(out_valid), 32'd0);
        check_eq("redir_addr",   imem_addr, 32'h0000_0010);
        next_cyc();
        check_eq("redir_valid2", 32'(out_valid), 32'd0);
        next_cyc();
        exp_pc = 32'h0000_0040;
        for (int i = 0; i < 4; i++) step_pop("redir");

        // ---------------- misaligned target / wrap ----------------
        br_valid  = 1'b1;
        br_target = 32'hFFFF_FFFE;
        next_cyc();
        br_valid = 1'b0;
        check_eq("wrap_addr0",  imem_addr, 32'h3FFF_FFFF);
        check_eq("wrap_valid1", 32'(out_valid), 32'd0);
        next_cyc();
        check_eq("wrap_addr1",  imem_addr, 32'h0000_0000);
        check_eq("wrap_valid2", 32'(out_valid), 32'd0);
        next_cyc();
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) step_pop("wrap");

        // ---------------- halt / resume ----------------
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) step_pop("halt_drain");
        check_eq("halt_valid1", 32'(out_valid), 32'd0);
        next_cyc();
        check_eq("halt_valid2", 32'(out_valid), 32'd0);
        check_eq("halt_addr",   imem_addr, exp_pc >> 2);
        fetch_en = 1'b1;
        expect_start("resume");
        for (int i = 0; i < 3; i++) step_pop("resume");

        // ---------------- asynchronous reset mid-stream ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_addr",  imem_addr, RESET_PC >> 2);
`ifdef FETCH_PERF_EN
        check_eq("arst_perf_f", perf_fetched,  32'd0);
        check_eq("arst_perf_b", perf_bubble,   32'd0);
        check_eq("arst_perf_r", perf_redirect, 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        next_cyc();
        exp_pc = RESET_PC;
        expect_start("restart");
        for (int i = 0; i < 3; i++) step_pop("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
